pipe_adder_tree: RTL and testbench
==================================

# pipe_adder_tree

Pipelined, parametrised sign-magnitude adder tree that reduces M fixed-point operands to one sum. It has a per-vector ReLU mode, magnitude saturation with an overflow flag, and a valid handshake. It sits between the multiplier array and the activation/output stage of a neuron datapath. It accepts one operand vector per clock and emits results in order after a fixed latency.

## Interface
- M, 8: operand count; power of two, 2..64.
- N, 32: word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- INTBITS, 12: integer bits, including the sign bit. Informational only.
- FRACBITS, 20: fraction bits; INTBITS+FRACBITS == N. Informational only, since the arithmetic is format-agnostic.
- STAGES, log2(M): derived localparam; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand vector valid this cycle.
- operand  in  N*M  operand i at operand[N*(i+1)-1 -: N].
- relu_en  in  1  ReLU mode for this vector; sampled with in_valid.
- out_valid  out  1  result valid; one-cycle pulse per accepted vector.
- result  out  N  sign-magnitude sum.
- out_sat  out  1  set if any addition for this vector saturated.

## Operation
- Number format: sign-magnitude; -0 (sign=1, magnitude=0) on any input is treated as +0.
- Binary tree of STAGES register levels.
  - Level k holds M/2^(k+1) partial sums.
  - Each partial sum carries its vector's valid, relu_en and sat bits alongside it.
- Pairwise add a+b:
  - Same sign: magnitude = |a|+|b| computed at N bits; sign = common sign.
  - Different signs: magnitude = larger minus smaller; sign = sign of the larger magnitude.
  - Zero magnitude always yields sign 0, so -0 is never produced.
- Saturation:
  - If the same-sign magnitude sum exceeds 2^(N-1)-1, clamp the magnitude to 2^(N-1)-1, keep the sign, and set sat.
  - Clamping happens at the stage where the overflow occurs; the clamped value propagates onward.
  - The sat bit ORs through the tree.
- Final level:
  - If relu_en is set and the sum is negative, result becomes 0.
  - out_sat is unaffected by ReLU.
- No backpressure: the downstream stage must accept every out_valid pulse.
- in_valid=0 inserts a bubble; bubbles propagate and produce no out_valid.
- Operand and relu_en are don't-care when in_valid=0. Their data may still propagate internally, but out_valid stays 0 for those slots.

## Timing
- Latency: a vector sampled at edge t produces out_valid=1, with its result and out_sat, in the cycle after edge t+STAGES-1. That is STAGES clocks; 3 for M=8.
- Throughput: one vector per clock; results leave in input order.
- Output hold: result and out_sat hold their last valid value while out_valid=0.
- Reset values: out_valid=0, result=0, out_sat=0, and all internal valid bits 0.
- Reset mid-operation:
  - All in-flight vectors are discarded; no out_valid appears for them after reset.
  - A vector presented in the same cycle as rst=1 is dropped.
  - The first vector accepted after rst falls sees the normal latency.
- Simultaneous events: a new input and a pipeline output in the same cycle are independent; there is no structural hazard.
- M=2: STAGES=1; the single add and ReLU complete in one register level.

## Test plan
- Single vector: M=8, N=32, all operands 0x00100000 (1.0), relu_en=1, one in_valid pulse.
  - Required: out_valid exactly 3 cycles later for one cycle, result=0x00800000, out_sat=0.
- Mixed signs and ReLU: four operands 0x00100000 and four 0x80180000 (-1.5).
  - relu_en=0 -> result=0x80200000 (-2.0).
  - relu_en=1 -> result=0x00000000.
- Cancellation and -0: operands {1.0, -1.0} x4, then all 0x80000000.
  - Required: result=0x00000000 both times, sign bit 0, out_sat=0.
- Saturation: all operands 0x7FFFFFFF -> result=0x7FFFFFFF, out_sat=1.
  - All operands 0xFFFFFFFF with relu_en=0 -> result=0xFFFFFFFF, out_sat=1.
  - Same with relu_en=1 -> result=0, out_sat=1.
- Streaming: 6 vectors back-to-back with a one-cycle bubble after the third; operand values 1.0·k for vector k.
  - Required: 6 out_valid pulses in order, with the bubble preserved, results 8.0·k.
- Reset mid-flight: stream 3 vectors, assert rst for one cycle on the edge after the 3rd.
  - Required: no further out_valid, result=0, out_sat=0.
  - A fresh vector afterwards returns its result 3 cycles after acceptance.

Source files
------------

// File: rtl/pipe_adder_tree.sv
// Pipelined sign-magnitude adder tree.
// Reduces M operands to one sum over log2(M) register levels, with
// magnitude saturation, an OR-ed saturation flag and a per-vector ReLU.
module pipe_adder_tree #(
    parameter int M        = 8,
    parameter int N        = 32,
    parameter int INTBITS  = 12,
    parameter int FRACBITS = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N*M-1:0]   operand,
    input  logic             relu_en,
    output logic             out_valid,
    output logic [N-1:0]     result,
    output logic             out_sat
);

    localparam int STAGES = $clog2(M);
    localparam int LAST   = STAGES - 1;

    // Reject parameter sets the tree cannot be built for
    if ((M < 2) || (M > 64) || ((M & (M - 1)) != 0)) begin : g_bad_count
        $error("pipe_adder_tree: M must be a power of two in 2..64");
    end
    if (INTBITS + FRACBITS != N) begin : g_bad_format
        $error("pipe_adder_tree: INTBITS + FRACBITS must equal N");
    end

    // Sign-magnitude pairwise add; returns {sat, sign, magnitude}.
    // A zero magnitude is always forced to sign 0 so -0 never leaves.
    function automatic logic [N:0] add_sm(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-2:0] mag_a;
        logic [N-2:0] mag_b;
        logic         sgn_a;
        logic         sgn_b;
        logic [N-1:0] mag_sum;
        logic [N-2:0] mag_res;
        logic         sgn_res;
        logic         sat;
        mag_a   = a[N-2:0];
        mag_b   = b[N-2:0];
        sgn_a   = a[N-1] & (|mag_a);
        sgn_b   = b[N-1] & (|mag_b);
        sat     = 1'b0;
        mag_sum = '0;
        if (sgn_a == sgn_b) begin
            mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
            if (mag_sum[N-1]) begin
                mag_res = '1;
                sat     = 1'b1;
            end else begin
                mag_res = mag_sum[N-2:0];
            end
            sgn_res = sgn_a;
        end else if (mag_a >= mag_b) begin
            mag_res = mag_a - mag_b;
            sgn_res = sgn_a;
        end else begin
            mag_res = mag_b - mag_a;
            sgn_res = sgn_b;
        end
        if (mag_res == '0) begin
            sgn_res = 1'b0;
        end
        return {sat, sgn_res, mag_res};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        localparam int CNT = M >> (k + 1);

        logic [N-1:0] src     [2*CNT];
        logic         src_sat [2*CNT];
        logic         src_valid;
        logic         src_relu;

        logic [N-1:0] sum_d   [CNT];
        logic         add_sat [CNT];
        logic         sat_d   [CNT];

        logic [N-1:0] sum_q   [CNT];
        logic         sat_q   [CNT];
        logic         valid_q;
        logic         relu_q;

        if (k == 0) begin : g_in
            for (genvar i = 0; i < 2*CNT; i++) begin : g_op
                assign src[i]     = operand[N*(i+1)-1 -: N];
                assign src_sat[i] = 1'b0;
            end
            assign src_valid = in_valid;
            assign src_relu  = relu_en;
        end else begin : g_chain
            for (genvar i = 0; i < 2*CNT; i++) begin : g_op
                assign src[i]     = g_lvl[k-1].sum_q[i];
                assign src_sat[i] = g_lvl[k-1].sat_q[i];
            end
            assign src_valid = g_lvl[k-1].valid_q;
            assign src_relu  = g_lvl[k-1].relu_q;
        end

        // Add adjacent pairs from the previous level and merge their sat flags
        always_comb begin
            for (int i = 0; i < CNT; i++) begin
                {add_sat[i], sum_d[i]} = add_sm(src[2*i], src[2*i+1]);
                sat_d[i] = add_sat[i] | src_sat[2*i] | src_sat[2*i+1];
            end
        end

        // Level register: valid advances every clock, data only with a real vector
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                relu_q  <= 1'b0;
                for (int i = 0; i < CNT; i++) begin
                    sum_q[i] <= '0;
                    sat_q[i] <= 1'b0;
                end
            end else begin
                valid_q <= src_valid;
                if (src_valid) begin
                    relu_q <= src_relu;
                    for (int i = 0; i < CNT; i++) begin
                        sum_q[i] <= sum_d[i];
                        sat_q[i] <= sat_d[i];
                    end
                end
            end
        end
    end

    logic [N-1:0] final_sum;

    // Final level drives the outputs; ReLU zeroes negative sums only
    always_comb begin
        final_sum = g_lvl[LAST].sum_q[0];
        result    = final_sum;
        if (g_lvl[LAST].relu_q && final_sum[N-1]) begin
            result = '0;
        end
    end

    assign out_valid = g_lvl[LAST].valid_q;
    assign out_sat   = g_lvl[LAST].sat_q[0];

endmodule

// File: tb/tb_pipe_adder_tree.sv
// Directed testbench for pipe_adder_tree with M=8, N=32 (12.20 format).
module tb_pipe_adder_tree;

    localparam int M = 8;
    localparam int N = 32;
    localparam logic [31:0] ONE     = 32'h0010_0000;
    localparam logic [31:0] NEG_ONE = 32'h8010_0000;
    localparam logic [31:0] NEG_1P5 = 32'h8018_0000;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [N*M-1:0] operand;
    logic           relu_en;
    logic           out_valid;
    logic [N-1:0]   result;
    logic           out_sat;

    int checks;
    int passed;

    pipe_adder_tree #(
        .M(M), .N(N), .INTBITS(12), .FRACBITS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .operand(operand),
        .relu_en(relu_en),
        .out_valid(out_valid),
        .result(result),
        .out_sat(out_sat)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Replicate one value into all operand slots
    function automatic logic [N*M-1:0] fillOps(input logic [31:0] v);
        logic [N*M-1:0] ops;
        for (int i = 0; i < M; i++) ops[N*(i+1)-1 -: N] = v;
        return ops;
    endfunction

    // Even slots get a, odd slots get b
    function automatic logic [N*M-1:0] altOps(input logic [31:0] a, input logic [31:0] b);
        logic [N*M-1:0] ops;
        for (int i = 0; i < M; i++) ops[N*(i+1)-1 -: N] = (i % 2 == 0) ? a : b;
        return ops;
    endfunction

    // Lower half of the slots get a, upper half get b
    function automatic logic [N*M-1:0] splitOps(input logic [31:0] a, input logic [31:0] b);
        logic [N*M-1:0] ops;
        for (int i = 0; i < M; i++) ops[N*(i+1)-1 -: N] = (i < M/2) ? a : b;
        return ops;
    endfunction

    // Single comparison point; counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Send one vector, wait for its result, check latency, value, sat and pulse width
    task automatic applyStimulus(input string tag, input logic [N*M-1:0] ops, input logic relu,
                                 input logic [31:0] expRes, input logic expSat);
        int lat;
        operand  = ops;
        relu_en  = relu;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 3);
        checkOutput({tag, "_result"}, result, expRes);
        checkOutput({tag, "_sat"}, {31'd0, out_sat}, {31'd0, expSat});
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_hold"}, result, expRes);
    endtask

    int hitCycle[$];
    logic [31:0] hitRes[$];
    int expCycle[6] = '{2, 3, 4, 6, 7, 8};
    int lateHits;

    initial begin
        checks   = 0;
        passed   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        operand  = '0;
        relu_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_sat", {31'd0, out_sat}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus("single", fillOps(ONE), 1'b1, 32'h0080_0000, 1'b0);
        applyStimulus("mixed", splitOps(ONE, NEG_1P5), 1'b0, 32'h8020_0000, 1'b0);
        applyStimulus("mixed_relu", splitOps(ONE, NEG_1P5), 1'b1, 32'h0000_0000, 1'b0);
        applyStimulus("cancel", altOps(ONE, NEG_ONE), 1'b0, 32'h0000_0000, 1'b0);
        applyStimulus("negzero", fillOps(32'h8000_0000), 1'b0, 32'h0000_0000, 1'b0);
        applyStimulus("sat_pos", fillOps(32'h7FFF_FFFF), 1'b0, 32'h7FFF_FFFF, 1'b1);
        applyStimulus("sat_neg", fillOps(32'hFFFF_FFFF), 1'b0, 32'hFFFF_FFFF, 1'b1);
        applyStimulus("sat_neg_relu", fillOps(32'hFFFF_FFFF), 1'b1, 32'h0000_0000, 1'b1);

        // Streaming: vectors 1..3, one bubble, vectors 4..6
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 3) || (c >= 4 && c < 7);
            operand  = fillOps(ONE * ((c < 3) ? c + 1 : c));
            relu_en  = 1'b0;
            @(posedge clk); #1;
            if (out_valid) begin
                hitCycle.push_back(c);
                hitRes.push_back(result);
            end
        end
        in_valid = 1'b0;
        checkOutput("stream_count", hitCycle.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("stream_cycle%0d", i),
                        (i < hitCycle.size()) ? hitCycle[i] : 32'hDEAD_DEAD, expCycle[i]);
            checkOutput($sformatf("stream_result%0d", i),
                        (i < hitRes.size()) ? hitRes[i] : 32'hDEAD_DEAD, 32'h0080_0000 * (i + 1));
        end

        // Reset mid-flight: three vectors, reset together with a fourth vector
        lateHits = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c <= 3);
            case (c)
                0:       operand = fillOps(32'h7FFF_FFFF);
                1:       operand = fillOps(ONE);
                2:       operand = fillOps(32'h0020_0000);
                default: operand = fillOps(32'h0030_0000);
            endcase
            rst = (c == 3);
            @(posedge clk); #1;
            if (c == 2) begin
                checkOutput("rst_pre_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("rst_pre_result", result, 32'h7FFF_FFFF);
                checkOutput("rst_pre_sat", {31'd0, out_sat}, 32'd1);
            end
            if (c == 3) begin
                checkOutput("rst_result", result, 32'd0);
                checkOutput("rst_sat", {31'd0, out_sat}, 32'd0);
            end
            if (c >= 3 && out_valid) lateHits++;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst_no_valid", lateHits, 0);
        applyStimulus("after_rst", fillOps(ONE), 1'b0, 32'h0080_0000, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
